// File: rtl/ctrl_pkg.sv
// Shared definitions for the HPS control-word decoder: word layout, opcodes,
// run-state encoding and a saturating-increment helper.
package ctrl_pkg;

    localparam int unsigned PARAM_W = 24;

    localparam int unsigned OPC_MSB  = 31;
    localparam int unsigned OPC_LSB  = 28;
    localparam int unsigned ADDR_MSB = 27;
    localparam int unsigned ADDR_LSB = 24;
    localparam int unsigned VAL_MSB  = 23;
    localparam int unsigned VAL_LSB  = 0;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_NOP       = 4'h0;
    localparam opcode_t OP_WRITE_REG = 4'h1;
    localparam opcode_t OP_START     = 4'h2;
    localparam opcode_t OP_ABORT     = 4'h3;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StRunning
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ctrl_word_decoder_if.sv
// Conduit bundle between the HPS control word source, the decoder and the
// compute core. The slave side is the decoder.
interface ctrl_word_decoder_if #(
    parameter int unsigned NUM_REGS = 8
) ();
    import ctrl_pkg::*;

    logic [31:0]                 control_data;
    logic                        control_set;
    logic [NUM_REGS*PARAM_W-1:0] params;
    logic                        start_valid;
    logic                        start_ready;
    logic                        core_done;
    logic                        abort;
    logic                        busy;
    logic [7:0]                  err_count;
    logic [15:0]                 cmd_count;

    modport master (
        output control_data, control_set, start_ready, core_done,
        input  params, start_valid, abort, busy, err_count, cmd_count
    );

    modport slave (
        input  control_data, control_set, start_ready, core_done,
        output params, start_valid, abort, busy, err_count, cmd_count
    );

endinterface

// File: rtl/rise_detect.sv
// Registered rising-edge detector; the history flop clears on reset so a level
// already high when reset releases is reported as a fresh edge.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (rst) sig_q <= 1'b0;
        else     sig_q <= sig;
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/ctrl_word_decoder.sv
// Decodes HPS control words into parameter writes and start/abort commands,
// tracks the core's run state and counts accepted and rejected commands.
module ctrl_word_decoder
    import ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS = 8
) (
    input logic               clk_clk,
    input logic               reset_reset,
    ctrl_word_decoder_if.slave bus
);

    logic                  set_rise;
    opcode_t               opcode;
    logic [3:0]            addr;
    logic [PARAM_W-1:0]    value;
    logic                  addr_ok;

    logic                  accept;
    logic                  reject;
    logic                  do_write;
    logic                  do_start;
    logic                  do_abort;

    state_e                state_q, state_d;
    logic                  abort_q;
    logic [7:0]            err_q;
    logic [15:0]           cmd_q;
    logic [PARAM_W-1:0]    regs_q [NUM_REGS];
    logic                  start_valid;
    logic                  busy;

    rise_detect u_set_rise (
        .clk  (clk_clk),
        .rst  (reset_reset),
        .sig  (bus.control_set),
        .rise (set_rise)
    );

    assign opcode  = bus.control_data[OPC_MSB:OPC_LSB];
    assign addr    = bus.control_data[ADDR_MSB:ADDR_LSB];
    assign value   = bus.control_data[VAL_MSB:VAL_LSB];
    assign addr_ok = {28'd0, addr} < NUM_REGS;

    always_comb begin
        accept   = 1'b0;
        reject   = 1'b0;
        do_write = 1'b0;
        do_start = 1'b0;
        do_abort = 1'b0;
        if (set_rise) begin
            case (opcode)
                OP_NOP: accept = 1'b1;
                OP_WRITE_REG: begin
                    if (state_q == StIdle && addr_ok) begin
                        accept   = 1'b1;
                        do_write = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                end
                OP_START: begin
                    if (state_q == StIdle) begin
                        accept   = 1'b1;
                        do_start = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                end
                OP_ABORT: begin
                    accept   = 1'b1;
                    do_abort = 1'b1;
                end
                default: reject = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) state_q <= StIdle;
        else             state_q <= state_d;
    end

    // Abort takes priority over a same-cycle handshake or completion.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (do_start) state_d = StArmed;
            StArmed: begin
                if (do_abort)             state_d = StIdle;
                else if (bus.start_ready) state_d = StRunning;
            end
            StRunning: begin
                if (do_abort || bus.core_done) state_d = StIdle;
            end
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        start_valid = 1'b0;
        busy        = 1'b0;
        unique case (state_q)
            StIdle:    ;
            StArmed: begin
                start_valid = 1'b1;
                busy        = 1'b1;
            end
            StRunning: busy = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            abort_q <= 1'b0;
            err_q   <= 8'd0;
            cmd_q   <= 16'd0;
        end else begin
            abort_q <= do_abort;
            if (reject) err_q <= sat_inc8(err_q);
            if (accept) cmd_q <= cmd_q + 16'd1;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (do_write && addr == 4'(i)) regs_q[i] <= value;
            end
        end
    end

    always_comb begin
        bus.params = '0;
        for (int i = 0; i < NUM_REGS; i++) bus.params[i*PARAM_W +: PARAM_W] = regs_q[i];
    end

    assign bus.start_valid = start_valid;
    assign bus.busy        = busy;
    assign bus.abort       = abort_q;
    assign bus.err_count   = err_q;
    assign bus.cmd_count   = cmd_q;

endmodule

// File: tb/tb_ctrl_word_decoder.sv
// Directed bench for ctrl_word_decoder: stimulus queues expected snapshots,
// a negedge monitor pops and compares them against the outputs.
module tb_ctrl_word_decoder;
    import ctrl_pkg::*;

    localparam int unsigned NR = 8;
    localparam int unsigned W  = NR * PARAM_W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ctrl_word_decoder_if #(.NUM_REGS(NR)) bus ();

    ctrl_word_decoder #(.NUM_REGS(NR)) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string          name;
        logic [W-1:0]   params;
        logic           busy;
        logic           sv;
        logic           abort;
        logic [7:0]     err;
        logic [15:0]    cmd;
        int             aborts;
    } exp_t;

    exp_t               exp_q[$];
    logic               snap_req = 1'b0;
    int                 tests = 0;
    int                 fails = 0;
    int                 abort_seen = 0;

    logic [PARAM_W-1:0] m_regs [NR];
    int                 m_err;
    int                 m_cmd;
    int                 m_aborts;

    task automatic check(input string nm, input string fld, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.abort === 1'b1) abort_seen = abort_seen + 1;
        if (snap_req) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                tests = tests + 1;
                fails = fails + 1;
                $display("FAIL scoreboard: got snapshot request, expected a queued entry");
            end else begin
                e = exp_q.pop_front();
                check(e.name, "params",      bus.params,          e.params);
                check(e.name, "busy",        W'(bus.busy),        W'(e.busy));
                check(e.name, "start_valid", W'(bus.start_valid), W'(e.sv));
                check(e.name, "abort",       W'(bus.abort),       W'(e.abort));
                check(e.name, "err_count",   W'(bus.err_count),   W'(e.err));
                check(e.name, "cmd_count",   W'(bus.cmd_count),   W'(e.cmd));
                check(e.name, "abort_pulses", W'(abort_seen),     W'(e.aborts));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue the model's view and let the monitor sample it on this cycle's negedge.
    task automatic expect_now(input string nm, input logic b, input logic sv, input logic ab);
        exp_t e;
        e.name = nm;
        for (int i = 0; i < NR; i++) e.params[i*PARAM_W +: PARAM_W] = m_regs[i];
        e.busy   = b;
        e.sv     = sv;
        e.abort  = ab;
        e.err    = 8'(m_err);
        e.cmd    = 16'(m_cmd);
        e.aborts = m_aborts;
        exp_q.push_back(e);
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
    endtask

    task automatic send(input logic [31:0] w);
        bus.control_data = w;
        bus.control_set  = 1'b1;
        step();
        bus.control_set  = 1'b0;
        step();
    endtask

    task automatic clear_model();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_err = 0;
        m_cmd = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.control_data = '0;
        bus.control_set  = 1'b0;
        bus.start_ready  = 1'b0;
        bus.core_done    = 1'b0;
        clear_model();
        m_aborts = 0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        expect_now("reset", 1'b0, 1'b0, 1'b0);

        send(32'h1200_00AB);
        m_regs[2] = 24'h0000AB;
        m_cmd = 1;
        expect_now("write_reg2", 1'b0, 1'b0, 1'b0);

        // START with start_ready low for five ARMED cycles, high on the sixth.
        bus.control_data = 32'h2000_0000;
        bus.control_set  = 1'b1;
        step();
        bus.control_set  = 1'b0;
        m_cmd = 2;
        for (int i = 0; i < 5; i++) expect_now($sformatf("armed_wait%0d", i), 1'b1, 1'b1, 1'b0);
        bus.start_ready = 1'b1;
        expect_now("armed_handshake", 1'b1, 1'b1, 1'b0);
        bus.start_ready = 1'b0;
        expect_now("running", 1'b1, 1'b0, 1'b0);

        // core_done in cycle M, START edge in M+1.
        bus.core_done = 1'b1;
        step();
        bus.core_done    = 1'b0;
        bus.control_data = 32'h2000_0000;
        bus.control_set  = 1'b1;
        expect_now("done_idle", 1'b0, 1'b0, 1'b0);
        bus.control_set  = 1'b0;
        m_cmd = 3;
        expect_now("restart_armed", 1'b1, 1'b1, 1'b0);
        bus.start_ready = 1'b1;
        step();
        bus.start_ready = 1'b0;
        expect_now("running2", 1'b1, 1'b0, 1'b0);

        send(32'h1100_0001);
        m_err = 1;
        expect_now("write_in_run", 1'b1, 1'b0, 1'b0);
        send(32'h7000_0000);
        m_err = 2;
        expect_now("illegal_op7", 1'b1, 1'b0, 1'b0);
        send(32'h1900_0000);
        m_err = 3;
        expect_now("write_addr9_run", 1'b1, 1'b0, 1'b0);

        // ABORT edge coincident with core_done while RUNNING.
        bus.control_data = 32'h3000_0000;
        bus.control_set  = 1'b1;
        bus.core_done    = 1'b1;
        step();
        bus.control_set  = 1'b0;
        bus.core_done    = 1'b0;
        m_cmd = 4;
        m_aborts = 1;
        expect_now("abort_vs_done", 1'b0, 1'b0, 1'b1);
        expect_now("abort_one_cycle", 1'b0, 1'b0, 1'b0);

        send(32'h1900_0000);
        m_err = 4;
        expect_now("write_addr9_idle", 1'b0, 1'b0, 1'b0);
        send(32'h0000_0000);
        m_cmd = 5;
        expect_now("nop", 1'b0, 1'b0, 1'b0);

        bus.control_data = 32'h1000_0005;
        bus.control_set  = 1'b1;
        repeat (10) step();
        bus.control_set  = 1'b0;
        m_regs[0] = 24'h000005;
        m_cmd = 6;
        expect_now("held_set_once", 1'b0, 1'b0, 1'b0);

        // ABORT edge coincident with start_ready while ARMED.
        send(32'h2000_0000);
        m_cmd = 7;
        expect_now("armed2", 1'b1, 1'b1, 1'b0);
        bus.control_data = 32'h3000_0000;
        bus.control_set  = 1'b1;
        bus.start_ready  = 1'b1;
        step();
        bus.control_set  = 1'b0;
        bus.start_ready  = 1'b0;
        m_cmd = 8;
        m_aborts = 2;
        expect_now("abort_vs_ready", 1'b0, 1'b0, 1'b1);
        expect_now("abort_no_run", 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) send(32'hF000_0000 | 32'(i));
        m_err = 255;
        expect_now("err_saturate", 1'b0, 1'b0, 1'b0);

        // Reset while ARMED: everything clears, no abort pulse.
        send(32'h2000_0000);
        m_cmd = 9;
        expect_now("armed3", 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_model();
        expect_now("reset_armed", 1'b0, 1'b0, 1'b0);
        expect_now("reset_quiet", 1'b0, 1'b0, 1'b0);

        // A set level held through reset counts as an edge right after release.
        bus.control_data = 32'h1300_0077;
        bus.control_set  = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        bus.control_set  = 1'b0;
        m_regs[3] = 24'h000077;
        m_cmd = 1;
        expect_now("set_through_reset", 1'b0, 1'b0, 1'b0);

        tests = tests + 1;
        if (exp_q.size() != 0) begin
            fails = fails + 1;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
